// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external 1-bit full-adder cell LSB
// first, accumulates its sum/carry and returns a registered WIDTH-bit result.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_cin,
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_c,
  input  logic             i_fa_sum,
  input  logic             i_fa_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum_out,
  output logic             o_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_bit_cnt;

  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_s_next;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_bit_cnt == CW'(WIDTH-1));
  assign w_s_next = {i_fa_sum, r_s_sh[WIDTH-1:1]};

  // Cell inputs are gated so the shared adder sees quiet zeros when idle.
  assign o_fa_a = w_run & r_a_sh[0];
  assign o_fa_b = w_run & r_b_sh[0];
  assign o_fa_c = w_run & r_carry;

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sum_out = r_sum_out;
  assign o_cout    = r_cout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
      r_sum_out <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      // Abort wins over everything; last result stays visible.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_s_sh    <= w_s_next;
          r_carry   <= i_fa_cout;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (w_last) begin
            r_sum_out <= w_s_next;
            r_cout    <= i_fa_cout;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a_sh    <= i_a_in;
            r_b_sh    <= i_b_in;
            r_carry   <= i_cin;
            r_bit_cnt <= '0;
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural full-adder cell, vector table,
// corner-case sequences and randomized adds against plain arithmetic.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] sum_out;
  logic         fa_a, fa_b, fa_c, fa_sum, fa_cout, busy, done, cout;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  logic prev_busy = 1'b0;
  logic prev_fa_cout = 1'b0;

  always #5 clk = ~clk;

  // The shared 1-bit full-adder cell the controller sequences.
  assign fa_sum  = fa_a ^ fa_b ^ fa_c;
  assign fa_cout = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
    .i_a_in(a_in), .i_b_in(b_in), .i_cin(cin),
    .o_fa_a(fa_a), .o_fa_b(fa_b), .o_fa_c(fa_c),
    .i_fa_sum(fa_sum), .i_fa_cout(fa_cout),
    .o_busy(busy), .o_done(done), .o_sum_out(sum_out), .o_cout(cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Continuous protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy <= 1'b0;
    end else begin
      if (busy && prev_busy) chk("fa_c_chain", {31'b0, fa_c}, {31'b0, prev_fa_cout});
      chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
      if (!busy) chk("fa_idle_zero", {29'b0, fa_a, fa_b, fa_c}, 32'd0);
      if (done) begin
        chk("done_after_run", {31'b0, prev_busy}, 32'd1);
        n_done++;
      end
      prev_busy    <= busy;
      prev_fa_cout <= fa_cout;
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge following done.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output int lat);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    chk("busy_rise", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum_out; co = cout;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    vec_t         tbl[6];
    logic [W-1:0] s;
    logic         co;
    logic [W:0]   ref_sum;
    int           lat, nd0, t, last_t, k_done;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

    // Reset state
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {24'b0, sum_out}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_fa", {29'b0, fa_a, fa_b, fa_c}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_add(tbl[i].a, tbl[i].b, tbl[i].c, s, co, lat);
      chk($sformatf("tbl%0d_lat", i), lat, W);
      chk($sformatf("tbl%0d_sum", i), {24'b0, s}, {24'b0, tbl[i].s});
      chk($sformatf("tbl%0d_cout", i), {31'b0, co}, {31'b0, tbl[i].co});
      chk($sformatf("tbl%0d_hold", i), {23'b0, cout, sum_out}, {23'b0, tbl[i].co, tbl[i].s});
    end

    // start during RUN ignored, operand inputs toggling
    nd0 = n_done;
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      a_in  = ~a_in;
      start = (lat == 3);
      if (lat == 3) a_in = 8'hAA;
    end
    start = 1'b0;
    chk("ign_lat", lat, W);
    chk("ign_sum", {23'b0, cout, sum_out}, 32'h046);
    repeat (3) @(posedge clk); #1;
    chk("ign_one_done", n_done - nd0, 32'd1);
    chk("ign_idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-RUN
    nd0 = n_done;
    a_in = 8'h0F; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", {23'b0, cout, sum_out}, 32'd0);
    chk("arst_fa", {29'b0, fa_a, fa_b, fa_c}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("arst_no_done", n_done - nd0, 32'd0);
    run_add(8'h01, 8'h01, 1'b0, s, co, lat);
    chk("arst_after_sum", {23'b0, co, s}, 32'h002);
    chk("arst_after_lat", lat, W);

    // clear mid-RUN keeps the previous result
    run_add(8'h5A, 8'h3C, 1'b0, s, co, lat);
    chk("clr_first", {23'b0, co, s}, 32'h096);
    nd0 = n_done;
    a_in = 8'hFF; b_in = 8'h01; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    repeat (12) @(posedge clk); #1;
    chk("clr_no_done", n_done - nd0, 32'd0);
    chk("clr_hold", {23'b0, cout, sum_out}, 32'h096);

    // start held high: back-to-back adds every WIDTH+1 cycles
    a_in = 8'h80; b_in = 8'h80; cin = 1'b0; start = 1'b1;
    t = 0; last_t = -1; k_done = 0;
    while (k_done < 4 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        chk("b2b_result", {23'b0, cout, sum_out}, 32'h100);
        if (last_t < 0) chk("b2b_first", t, W + 1);
        else            chk("b2b_period", t - last_t, W + 1);
        last_t = t;
        k_done++;
      end
    end
    start = 1'b0;
    chk("b2b_count", k_done, 32'd4);
    @(posedge clk); #1;

    // Randomized adds against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_add(ra, rb, rc, s, co, lat);
      chk("rnd_lat", lat, W);
      chk("rnd_result", {23'b0, co, s}, {23'b0, ref_sum});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences the team's single 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start handshake and drives the external cell's inputs from internal shift registers. It accumulates the cell's sum and carry outputs, then presents a registered WIDTH-bit result and carry-out with a one-cycle done pulse. It sits between a requesting datapath and one shared full-adder instance, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- clear  input  1  synchronous abort; returns to IDLE with no done pulse
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- fa_a  output  1  to full-adder cell input a
- fa_b  output  1  to full-adder cell input b
- fa_c  output  1  to full-adder cell carry input
- fa_sum  input  1  from full-adder cell sum; combinational, same cycle
- fa_cout  input  1  from full-adder cell carry-out; combinational, same cycle
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- sum_out  output  WIDTH  registered result; holds until the next accepted start
- cout  output  1  registered final carry; holds with sum_out

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - a_sh, b_sh: WIDTH-bit right-shift registers.
  - s_sh: WIDTH-bit accumulator, shifts right with fa_sum entering the MSB.
  - carry: 1 bit.
  - bit_cnt: $clog2(WIDTH) bits.
- IDLE/DONE with start=1 and clear=0:
  - a_sh<=a_in, b_sh<=b_in, carry<=cin, bit_cnt<=0.
  - Go to RUN.
- IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, every cycle:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry.
  - On the edge: s_sh<={fa_sum, s_sh[WIDTH-1:1]}, carry<=fa_cout, a_sh and b_sh shift right by 1, bit_cnt<=bit_cnt+1.
- RUN with bit_cnt==WIDTH-1:
  - sum_out<={fa_sum, s_sh[WIDTH-1:1]}, cout<=fa_cout.
  - Go to DONE.
- Outside RUN: fa_a, fa_b and fa_c are driven 0.
- start during RUN is ignored and is not queued.
- clear has priority over start and over RUN progress. It forces IDLE and leaves sum_out/cout unchanged.
- Operand inputs are don't-care except on the accepting edge. Changes to a_in/b_in during RUN do not affect the result.
- Result is {cout, sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1), with no overflow flag.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, sum_out=0, cout=0, fa_*=0.
  - All internal registers are 0.
- Reset asserted mid-RUN aborts the operation immediately and produces no done.
- Start accepted at edge E0 → busy=1 after E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- After E_WIDTH: busy=0, done=1 for exactly one cycle, sum_out/cout valid.
- Latency from start edge to done high is WIDTH cycles. Throughput is one add per WIDTH+1 cycles.
- Back-to-back: start=1 during the DONE cycle is accepted at the next edge, so busy rises in the cycle after done.
- busy and done are never high together. done is never high except in the cycle immediately following RUN.
- All outputs are registered except fa_a, fa_b and fa_c, which are decoded from state and registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start one cycle → busy for 8 cycles, then done=1 one cycle, sum_out=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout=1. a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout=1.
- Start a=0x12, b=0x34, then pulse start with a=0xAA at cycle 3 of RUN and toggle a_in every cycle → start ignored, sum_out=0x46, exactly one done.
- Start a=0x0F, b=0x01; drop rst_n in cycle 4 of RUN → outputs immediately 0, state IDLE, no done. After release, a new start a=0x01, b=0x01 gives sum_out=0x02.
- Complete an add giving 0x96; assert clear mid-RUN of a second add → back to IDLE, no done, sum_out still 0x96.
- Hold start=1 continuously with a=0x80, b=0x80, cin=0 → done every 9 cycles, each with sum_out=0x00 and cout=1. Monitor checks fa_c equals the previous fa_cout throughout RUN.
